mem_stream_port: RTL and testbench

- Single-port initiator for the MU0 dual-port memory; normally drives memory port 1.
- Moves a block of consecutive words in one of two directions:
  - memory to an output valid/ready stream (dump), or
  - an input valid/ready stream to memory (load).
- Used by the debug/loader path so the memory can be filled or inspected without the processor.

---
 rtl/mem_stream_port.sv | 171 +++++++++++++++++
 tb/tb_mem_stream_port.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stream_port.sv
// Block mover between the MU0 dual-port memory (port 1) and a valid/ready stream, in either direction.
// Optional running checksum of streamed words: define MEM_STREAM_CHECKSUM_EN.
module mem_stream_port #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 13
) (
  input  logic              Clk,
  input  logic              nReset,
  input  logic              cmd_start,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wen,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef MEM_STREAM_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready
);

  // state  | meaning
  // IDLE   | waiting for cmd_start
  // READ   | issuing memory reads, draining 2-entry buffer to out stream
  // WRITE  | accepting in stream words, writing them to memory
  // FINISH | last write in flight; done/busy update on exit
  typedef enum logic [1:0] {IDLE, READ, WRITE, FINISH} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cur;
  logic [LEN_W-1:0]  issue_rem;
  logic [LEN_W-1:0]  pop_rem;
  logic [DATA_W-1:0] fifo_head;
  logic [DATA_W-1:0] fifo_tail;
  logic [1:0]        fifo_cnt;
  logic              inflight;
  logic              accept;
  logic              pop;
  logic              issue;
  logic [2:0]        occ_nxt;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cmd_start) begin
          if (cmd_len == '0)   state_nxt = FINISH;
          else if (cmd_write)  state_nxt = WRITE;
          else                 state_nxt = READ;
        end
      end
      WRITE:   if (accept && issue_rem == LEN_W'(1)) state_nxt = FINISH;
      READ:    if (pop && pop_rem == LEN_W'(1))      state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (fifo_cnt != 2'd0);
    out_data  = fifo_head;
    accept    = (state == WRITE) && in_valid && in_ready;
    pop       = (state == READ) && out_valid && out_ready;
    // occupancy after this edge if no new read were issued; cap at 2
    occ_nxt   = {1'b0, fifo_cnt} + {2'b0, inflight} - {2'b0, pop};
    issue     = (state == READ) && (issue_rem != '0) && (occ_nxt < 3'd2);
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wen   <= 1'b0;
      in_ready  <= 1'b0;
      cur       <= '0;
      issue_rem <= '0;
      pop_rem   <= '0;
      fifo_head <= '0;
      fifo_tail <= '0;
      fifo_cnt  <= 2'd0;
      inflight  <= 1'b0;
`ifdef MEM_STREAM_CHECKSUM_EN
      checksum  <= '0;
`endif
    end else begin
      mem_wen  <= 1'b0;
      done     <= 1'b0;
      inflight <= issue;

      if (state == IDLE && cmd_start) begin
        cur       <= cmd_addr;
        issue_rem <= cmd_len;
        pop_rem   <= cmd_len;
        busy      <= 1'b1;
        in_ready  <= cmd_write && (cmd_len != '0);
`ifdef MEM_STREAM_CHECKSUM_EN
        checksum  <= '0;
`endif
      end

      if (state == FINISH) begin
        done <= 1'b1;
        busy <= 1'b0;
      end

      if (accept) begin
        mem_addr  <= cur;
        mem_wdata <= in_data;
        mem_wen   <= 1'b1;
        cur       <= cur + ADDR_W'(1);
        issue_rem <= issue_rem - LEN_W'(1);
        if (issue_rem == LEN_W'(1)) in_ready <= 1'b0;
`ifdef MEM_STREAM_CHECKSUM_EN
        checksum  <= checksum + in_data;
`endif
      end

      if (issue) begin
        mem_addr  <= cur;
        cur       <= cur + ADDR_W'(1);
        issue_rem <= issue_rem - LEN_W'(1);
      end

      if (pop) begin
        pop_rem <= pop_rem - LEN_W'(1);
`ifdef MEM_STREAM_CHECKSUM_EN
        checksum <= checksum + fifo_head;
`endif
      end

      // a read issued last edge lands in the buffer now
      case ({inflight, pop})
        2'b10: begin
          if (fifo_cnt == 2'd0) fifo_head <= mem_rdata;
          else                  fifo_tail <= mem_rdata;
          fifo_cnt <= fifo_cnt + 2'd1;
        end
        2'b01: begin
          fifo_head <= fifo_tail;
          fifo_cnt  <= fifo_cnt - 2'd1;
        end
        2'b11: begin
          if (fifo_cnt == 2'd1) begin
            fifo_head <= mem_rdata;
          end else begin
            fifo_head <= fifo_tail;
            fifo_tail <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stream_port.sv
// Directed self-checking bench for mem_stream_port with a negedge-updated memory model.
// Checksum checks are compiled in when MEM_STREAM_CHECKSUM_EN is defined.
module tb_mem_stream_port;

  logic        Clk = 1'b0;
  logic        nReset = 1'b0;
  logic        cmd_start = 1'b0;
  logic        cmd_write = 1'b0;
  logic [11:0] cmd_addr = '0;
  logic [12:0] cmd_len = '0;
  logic        busy, done;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_wen;
  logic [15:0] mem_rdata = '0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
`ifdef MEM_STREAM_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  logic [15:0] mem [0:4095];
  int passed = 0;
  int total = 0;
  int fails = 0;
  int pops = 0;

  mem_stream_port dut (
    .Clk(Clk), .nReset(nReset),
    .cmd_start(cmd_start), .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_rdata(mem_rdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
`ifdef MEM_STREAM_CHECKSUM_EN
    .checksum(checksum),
`endif
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (mem_wen) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    if (out_valid && out_ready) pops++;
    @(posedge Clk);
    #1;
  endtask

  logic [15:0] ld [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
  logic        rdy_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic        exp_v   [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [15:0] exp_d   [7] = '{16'h0, 16'h1111, 16'h1111, 16'h2222, 16'h2222, 16'h3333, 16'h0};
  logic [11:0] exp_a   [7] = '{12'h010, 12'h011, 12'h011, 12'h012, 12'h012, 12'h012, 12'h012};

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;

    // reset values
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wen", mem_wen, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 0);
`ifdef MEM_STREAM_CHECKSUM_EN
    chk("rst_checksum", checksum, 0);
`endif
    nReset = 1'b1;
    step();

    // load 4 words to 0x010
    cmd_start = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h010; cmd_len = 13'd4;
    in_valid = 1'b1; in_data = ld[0];
    step();
    cmd_start = 1'b0;
    chk("ld_busy", busy, 1);
    chk("ld_in_ready", in_ready, 1);
    chk("ld_wen_idle", mem_wen, 0);
    for (int i = 0; i < 4; i++) begin
      in_data = ld[i];
      step();
      chk("ld_wen", mem_wen, 1);
      chk("ld_addr", mem_addr, 32'h010 + i);
      chk("ld_wdata", mem_wdata, ld[i]);
    end
    in_valid = 1'b0;
    chk("ld_in_ready_last", in_ready, 0);
    chk("ld_busy_finish", busy, 1);
    chk("ld_done_early", done, 0);
    step();
    chk("ld_done", done, 1);
    chk("ld_busy_end", busy, 0);
    chk("ld_wen_end", mem_wen, 0);
`ifdef MEM_STREAM_CHECKSUM_EN
    chk("ld_checksum", checksum, 16'hAAAA);
`endif
    step();
    chk("ld_done_pulse", done, 0);
    chk("ld_mem13", mem[12'h013], 16'h4444);

    // dump 4 words from 0x010, out_ready held high
    cmd_start = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h010; cmd_len = 13'd4;
    out_ready = 1'b1;
    step();
    cmd_start = 1'b0;
    chk("dp_valid_e0", out_valid, 0);
    step();
    chk("dp_valid_e1", out_valid, 0);
    chk("dp_addr_e1", mem_addr, 12'h010);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("dp_valid", out_valid, 1);
      chk("dp_data", out_data, ld[i]);
    end
    step();
    chk("dp_valid_end", out_valid, 0);
    chk("dp_done_early", done, 0);
    step();
    chk("dp_done", done, 1);
    chk("dp_busy", busy, 0);
`ifdef MEM_STREAM_CHECKSUM_EN
    chk("dp_checksum", checksum, 16'hAAAA);
`endif
    step();
    chk("dp_done_pulse", done, 0);

    // dump 3 words with stalls
    cmd_start = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h010; cmd_len = 13'd3;
    out_ready = 1'b0;
    step();
    cmd_start = 1'b0;
    pops = 0;
    for (int i = 0; i < 7; i++) begin
      out_ready = rdy_pat[i];
      step();
      chk("st_valid", out_valid, exp_v[i]);
      if (exp_v[i]) chk("st_data", out_data, exp_d[i]);
      chk("st_addr", mem_addr, exp_a[i]);
    end
    chk("st_pops", pops, 3);
    chk("st_busy_finish", busy, 1);
    step();
    chk("st_done", done, 1);
    out_ready = 1'b0;
    step();

    // load across address wrap
    cmd_start = 1'b1; cmd_write = 1'b1; cmd_addr = 12'hFFF; cmd_len = 13'd2;
    step();
    cmd_start = 1'b0;
    in_valid = 1'b1; in_data = 16'hAAAA;
    step();
    chk("wr_addr0", mem_addr, 12'hFFF);
    in_data = 16'h5555;
    step();
    chk("wr_addr1", mem_addr, 12'h000);
    chk("wr_wen1", mem_wen, 1);
    in_valid = 1'b0;
    step();
    chk("wr_done", done, 1);
    chk("wr_memFFF", mem[12'hFFF], 16'hAAAA);
    chk("wr_mem000", mem[12'h000], 16'h5555);
    step();

    // zero-length command
    cmd_start = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h200; cmd_len = 13'd0;
    out_ready = 1'b1;
    step();
    cmd_start = 1'b0;
    chk("z_busy", busy, 1);
    chk("z_valid", out_valid, 0);
    chk("z_wen", mem_wen, 0);
    step();
    chk("z_done", done, 1);
    chk("z_valid2", out_valid, 0);
    chk("z_wen2", mem_wen, 0);
    out_ready = 1'b0;
    step();

    // cmd_start ignored while busy
    cmd_start = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h020; cmd_len = 13'd1;
    step();
    cmd_addr = 12'h300; cmd_write = 1'b0; cmd_len = 13'd5;
    step();
    step();
    chk("ig_busy", busy, 1);
    chk("ig_in_ready", in_ready, 1);
    chk("ig_wen", mem_wen, 0);
    cmd_start = 1'b0;
    in_valid = 1'b1; in_data = 16'h0BEE;
    step();
    in_valid = 1'b0;
    chk("ig_addr", mem_addr, 12'h020);
    chk("ig_wdata", mem_wdata, 16'h0BEE);
    chk("ig_in_ready_last", in_ready, 0);
    step();
    chk("ig_done", done, 1);
    step();

    // reset in the middle of a 5-word load
    cmd_start = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h040; cmd_len = 13'd5;
    step();
    cmd_start = 1'b0;
    in_valid = 1'b1; in_data = 16'h8000;
    step();
    in_data = 16'h8001;
    step();
    chk("rm_wen_before", mem_wen, 1);
`ifdef MEM_STREAM_CHECKSUM_EN
    chk("rm_checksum", checksum, 16'h0001);
`endif
    nReset = 1'b0;
    #1;
    chk("rm_wen", mem_wen, 0);
    chk("rm_busy", busy, 0);
    chk("rm_in_ready", in_ready, 0);
    chk("rm_done", done, 0);
    #2;
    nReset = 1'b1;
    in_valid = 1'b0;
    step();
    chk("rm_done_after", done, 0);
    chk("rm_busy_after", busy, 0);
    chk("rm_wen_after", mem_wen, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
